// File: rtl/pipe_reg_de.sv
// Decode-to-execute pipeline register with a load-use interlock, global hold and branch flush.
// Optional macro LOAD_USE_PERF_EN adds a saturating count of load-use bubbles (o_bubble_cnt).
module pipe_reg_de #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_hold,
    input  logic              i_flush_E,
    input  logic              i_valid_D,
    input  logic [PC_W-1:0]   i_pc_D,
    input  logic [31:0]       i_instr_D,
    input  logic [DATA_W-1:0] i_rs1_data_D,
    input  logic [DATA_W-1:0] i_rs2_data_D,
    input  logic [DATA_W-1:0] i_imm_D,
    input  logic [4:0]        i_rs1_addr_D,
    input  logic [4:0]        i_rs2_addr_D,
    input  logic              i_rs1_used_D,
    input  logic              i_rs2_used_D,
    input  logic [4:0]        i_rd_addr_D,
    input  logic              i_rd_wren_D,
    input  logic              i_mem_rden_D,
    input  logic              i_mem_wren_D,
    input  logic [CTRL_W-1:0] i_ctrl_D,
    output logic              o_valid_E,
    output logic [PC_W-1:0]   o_pc_E,
    output logic [31:0]       o_instr_E,
    output logic [DATA_W-1:0] o_rs1_data_E,
    output logic [DATA_W-1:0] o_rs2_data_E,
    output logic [DATA_W-1:0] o_imm_E,
    output logic [4:0]        o_rs1_addr_E,
    output logic [4:0]        o_rs2_addr_E,
    output logic [4:0]        o_rd_addr_E,
    output logic              o_rd_wren_E,
    output logic              o_mem_rden_E,
    output logic              o_mem_wren_E,
    output logic [CTRL_W-1:0] o_ctrl_E,
    output logic              o_stall_FD,
`ifdef LOAD_USE_PERF_EN
    output logic [31:0]       o_bubble_cnt,
`endif
    output logic              o_bubble_E
);

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [31:0]       instr;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
        logic              rd_wren;
        logic              mem_rden;
        logic              mem_wren;
        logic [CTRL_W-1:0] ctrl;
    } bundle_t;

    bundle_t d_bundle;
    bundle_t e_d, e_q;
    logic    bubble_d, bubble_q;
    logic    haz;

    // Side effects are gated by valid so a non-instruction can never write.
    always_comb begin
        d_bundle          = '0;
        d_bundle.valid    = i_valid_D;
        d_bundle.pc       = i_pc_D;
        d_bundle.instr    = i_instr_D;
        d_bundle.rs1_data = i_rs1_data_D;
        d_bundle.rs2_data = i_rs2_data_D;
        d_bundle.imm      = i_imm_D;
        d_bundle.rs1_addr = i_rs1_addr_D;
        d_bundle.rs2_addr = i_rs2_addr_D;
        d_bundle.rd_addr  = i_rd_addr_D;
        d_bundle.rd_wren  = i_rd_wren_D & i_valid_D;
        d_bundle.mem_rden = i_mem_rden_D & i_valid_D;
        d_bundle.mem_wren = i_mem_wren_D & i_valid_D;
        d_bundle.ctrl     = i_ctrl_D;
    end

    always_comb begin
        haz = e_q.valid && e_q.mem_rden && (e_q.rd_addr != 5'd0) && i_valid_D &&
              ((i_rs1_used_D && (i_rs1_addr_D == e_q.rd_addr)) ||
               (i_rs2_used_D && (i_rs2_addr_D == e_q.rd_addr)));
    end

    // A flush discards the consumer anyway, so there is nothing to hold back.
    assign o_stall_FD = haz & ~i_flush_E;

    always_comb begin
        e_d      = e_q;
        bubble_d = bubble_q;
        if (i_hold) begin
            e_d      = e_q;
            bubble_d = bubble_q;
        end else if (i_flush_E || haz) begin
            e_d      = '0;
            bubble_d = 1'b1;
        end else begin
            e_d      = d_bundle;
            bubble_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            e_q      <= '0;
            bubble_q <= 1'b0;
        end else begin
            e_q      <= e_d;
            bubble_q <= bubble_d;
        end
    end

`ifdef LOAD_USE_PERF_EN
    logic [31:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (haz && !i_hold && !i_flush_E && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_bubble_cnt = cnt_q;
`endif

    assign o_valid_E    = e_q.valid;
    assign o_pc_E       = e_q.pc;
    assign o_instr_E    = e_q.instr;
    assign o_rs1_data_E = e_q.rs1_data;
    assign o_rs2_data_E = e_q.rs2_data;
    assign o_imm_E      = e_q.imm;
    assign o_rs1_addr_E = e_q.rs1_addr;
    assign o_rs2_addr_E = e_q.rs2_addr;
    assign o_rd_addr_E  = e_q.rd_addr;
    assign o_rd_wren_E  = e_q.rd_wren;
    assign o_mem_rden_E = e_q.mem_rden;
    assign o_mem_wren_E = e_q.mem_wren;
    assign o_ctrl_E     = e_q.ctrl;
    assign o_bubble_E   = bubble_q;

endmodule

// File: doc/pipe_reg_de.md
Name: pipe_reg_de

Overview:
- Decode-to-execute pipeline register with a built-in load-use interlock.
- Captures the D-stage instruction bundle each cycle and presents it as the E-stage bundle. This drives the E-side rd address and write-enable that the D-stage branch forwarding logic compares against.
- Detects load-use hazards between E and D, stalls F/D, and injects a bubble into E.
- Supports global hold (memory wait) and branch flush.

Parameters:
- PC_W, 32, program counter width
- DATA_W, 32, register data / immediate width
- CTRL_W, 16, opaque ALU/branch/writeback control bundle width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_hold  in  1  global freeze; E register keeps its contents
- i_flush_E  in  1  branch/jump redirect; E loads a bubble
- i_valid_D  in  1  D holds a real instruction
- i_pc_D  in  PC_W  D-stage PC
- i_instr_D  in  32  D-stage instruction word
- i_rs1_data_D, i_rs2_data_D  in  DATA_W  register file read data
- i_imm_D  in  DATA_W  decoded immediate
- i_rs1_addr_D, i_rs2_addr_D  in  5  source register addresses
- i_rs1_used_D, i_rs2_used_D  in  1  instruction actually reads rs1/rs2
- i_rd_addr_D  in  5  destination register
- i_rd_wren_D, i_mem_rden_D, i_mem_wren_D  in  1  regfile write, load, store
- i_ctrl_D  in  CTRL_W  remaining control
- o_valid_E, o_pc_E, o_instr_E, o_rs1_data_E, o_rs2_data_E, o_imm_E, o_rs1_addr_E, o_rs2_addr_E, o_rd_addr_E, o_rd_wren_E, o_mem_rden_E, o_mem_wren_E, o_ctrl_E  out  matching widths  registered E-stage bundle
- o_stall_FD  out  1  hold PC and F/D register (combinational)
- o_bubble_E  out  1  E holds an injected bubble (registered)

Behaviour:
- Reset (i_rst_n=0, async):
  - Every registered output is 0, including o_valid_E and o_bubble_E.
  - o_stall_FD therefore evaluates to 0.
- Bubble contents:
  - All bundle fields are 0; o_valid_E=0.
  - o_rd_wren_E, o_mem_rden_E and o_mem_wren_E are 0, and o_rd_addr_E is x0.
  - A bubble never matches any forwarding or hazard compare.
- Load-use hazard (combinational):
  - haz is high when all of the following hold:
    - o_valid_E=1
    - o_mem_rden_E=1
    - o_rd_addr_E!=0
    - i_valid_D=1
    - (i_rs1_used_D and i_rs1_addr_D==o_rd_addr_E) or (i_rs2_used_D and i_rs2_addr_D==o_rd_addr_E)
- Stall output:
  - o_stall_FD = haz and not i_flush_E.
  - o_stall_FD is independent of i_hold; the global freeze is distributed separately.
- Per-edge update priority, highest first:
  1. i_hold=1: E holds all contents, including o_bubble_E.
  2. i_flush_E=1: E loads a bubble, o_bubble_E=1.
  3. haz=1: E loads a bubble, o_bubble_E=1. D is held by o_stall_FD, so the consumer re-presents next cycle.
  4. Otherwise: E loads the D bundle. o_valid_E=i_valid_D and o_bubble_E=0.
- Latency:
  - One cycle from D to E.
  - A load-use hazard costs exactly one bubble. Next cycle the load has left E, haz clears, and the consumer advances.
- i_valid_D=0 with no hazard: E loads the D bundle with o_valid_E=0. Write-enables are still forced to 0, so invalid entries never write.
- rd=x0 load: never stalls.
- Back-to-back loads to the same rd with a dependent third instruction: each dependency stalls once only.
- Reset asserted mid-stall: bubble state is cleared immediately. The first edge after reset release loads D normally.

Optional Feature:
- Macro LOAD_USE_PERF_EN.
- Defined:
  - Adds output o_bubble_cnt, 32-bit.
  - Increments on each edge where a load-use bubble is inserted (haz=1, i_hold=0, i_flush_E=0).
  - Saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: no port and no counter; behaviour otherwise identical.

Test Plan:
- Straight-line: D {pc=0x100, rd=5, rd_wren=1, valid=1} at edge N -> at N+1 o_pc_E=0x100, o_rd_addr_E=5, o_rd_wren_E=1, o_stall_FD=0.
- Load-use: E=lw x7 (mem_rden=1, rd=7); D=add reading rs2=7 with rs2_used=1 -> o_stall_FD=1 this cycle. Next edge: E bubble (o_valid_E=0, o_bubble_E=1, o_rd_wren_E=0), stall drops, add enters E on the following edge.
- No false stall: E=lw x0, D reads x0 -> o_stall_FD=0. Also E=lw x7 with D rs1=7 but rs1_used=0 -> o_stall_FD=0.
- Flush vs hazard: load-use present and i_flush_E=1 -> o_stall_FD=0, E loads bubble; with LOAD_USE_PERF_EN the counter is unchanged.
- Hold: i_hold=1 for 3 cycles with D changing -> E outputs frozen at prior values. On release, E loads the current D bundle.
- Async reset mid-operation: drop i_rst_n between edges while E holds lw x7 -> all outputs 0 without a clock edge, o_stall_FD=0, o_bubble_cnt=0 when enabled.
